// File: rtl/cmp_unit_pipe_if.sv
// -----------------------------------------------------------------------------
// cmp_unit_pipe_if
// Operand/result bundle for the pipelined compare unit.
//   A, B        operands (WIDTH)
//   ALU_FUN     function select (4), captured with the operands
//   CMP_Enable  input valid        CMP_Ready  input ready
//   CMP_OUT     result (WIDTH)     CMP_Flag   output valid
//   OUT_Ready   downstream ready   ACC_Valid  accumulator holds a sample
// master = the ALU sequencer driving operands, slave = cmp_unit_pipe.
// -----------------------------------------------------------------------------
interface cmp_unit_pipe_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [3:0]       ALU_FUN;
   logic             CMP_Enable;
   logic             CMP_Ready;
   logic [WIDTH-1:0] CMP_OUT;
   logic             CMP_Flag;
   logic             OUT_Ready;
   logic             ACC_Valid;

   modport master (
      output A, B, ALU_FUN, CMP_Enable, OUT_Ready,
      input  CMP_Ready, CMP_OUT, CMP_Flag, ACC_Valid
   );

   modport slave (
      input  A, B, ALU_FUN, CMP_Enable, OUT_Ready,
      output CMP_Ready, CMP_OUT, CMP_Flag, ACC_Valid
   );
endinterface

// File: rtl/cmp_unit_pipe.sv
// -----------------------------------------------------------------------------
// cmp_unit_pipe
// Two-stage pipelined compare unit with a running min/max accumulator.
//   CLK   clock, rising edge
//   RST   asynchronous, active-low reset
//   bus   cmp_unit_pipe_if.slave (operands, function, handshake, result)
//   HIT_CNT (16) only when CMP_HIT_CNT_EN is defined: saturating count of
//         compare-mode ops (01/10/11) with a nonzero result; cleared by reset
//         and by an accumulator clear op.
// Optional feature macro: CMP_HIT_CNT_EN.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. The producer keeps valid and payload stable until that edge; ready may
// change at any time and never depends on valid.
//   input side : valid = CMP_Enable, ready = CMP_Ready
//   output side: valid = CMP_Flag,   ready = OUT_Ready
//
// Stage 1 registers A/B/ALU_FUN. Stage 2 computes the result and registers
// CMP_OUT/CMP_Flag; the accumulator is updated in the same step, so a
// following accumulator op in stage 1 always sees the updated value.
// -----------------------------------------------------------------------------
module cmp_unit_pipe #(
   parameter int WIDTH      = 16,
   parameter bit SIGNED_DEF = 1'b0
) (
   input  logic          CLK,
   input  logic          RST,
   cmp_unit_pipe_if.slave bus
`ifdef CMP_HIT_CNT_EN
   ,
   output logic [15:0]   HIT_CNT
`endif
);

   logic             rdy_en;
   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [3:0]       s1_fun;

   logic [WIDTH-1:0] cmp_out;
   logic             cmp_flag;
   logic [WIDTH-1:0] acc;
   logic             acc_valid;

   logic             s2_ready;
   logic             s1_load;
   logic             s2_load;

   logic             sgn;
   logic             ab_eq;
   logic             ab_gt;
   logic             ab_lt;
   logic             a_gt_acc;
   logic             a_lt_acc;

   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] acc_nxt;
   logic             acc_valid_nxt;
   logic             hit;
   logic             acc_clr;

   // rdy_en keeps the input closed for the first cycle after reset release.
   assign s2_ready      = !cmp_flag | bus.OUT_Ready;
   assign bus.CMP_Ready = rdy_en & (!s1_valid | s2_ready);
   assign s1_load       = bus.CMP_Enable & bus.CMP_Ready;
   assign s2_load       = s1_valid & s2_ready;

   assign bus.CMP_OUT   = cmp_out;
   assign bus.CMP_Flag  = cmp_flag;
   assign bus.ACC_Valid = acc_valid;

   // Each op carries its own signedness; ACC bits are reinterpreted as-is.
   assign sgn      = s1_fun[2] | SIGNED_DEF;
   assign ab_eq    = (s1_a == s1_b);
   assign ab_gt    = sgn ? ($signed(s1_a) > $signed(s1_b)) : (s1_a > s1_b);
   assign ab_lt    = sgn ? ($signed(s1_a) < $signed(s1_b)) : (s1_a < s1_b);
   assign a_gt_acc = sgn ? ($signed(s1_a) > $signed(acc))  : (s1_a > acc);
   assign a_lt_acc = sgn ? ($signed(s1_a) < $signed(acc))  : (s1_a < acc);

   always_comb begin
      res           = '0;
      acc_nxt       = acc;
      acc_valid_nxt = acc_valid;
      hit           = 1'b0;
      acc_clr       = 1'b0;
      if (!s1_fun[3]) begin
         unique case (s1_fun[1:0])
            2'b00:   res = '0;
            2'b01:   res = ab_eq ? WIDTH'(1) : '0;
            2'b10:   res = ab_gt ? WIDTH'(2) : '0;
            default: res = ab_lt ? WIDTH'(3) : '0;
         endcase
         hit = (s1_fun[1:0] != 2'b00) && (res != '0);
      end else begin
         unique case (s1_fun[1:0])
            2'b00: begin
               acc_nxt       = '0;
               acc_valid_nxt = 1'b0;
               acc_clr       = 1'b1;
            end
            2'b01: begin
               // Equal values keep ACC; the bits are identical either way.
               acc_nxt       = (!acc_valid || a_gt_acc) ? s1_a : acc;
               acc_valid_nxt = 1'b1;
               res           = acc_nxt;
            end
            2'b10: begin
               acc_nxt       = (!acc_valid || a_lt_acc) ? s1_a : acc;
               acc_valid_nxt = 1'b1;
               res           = acc_nxt;
            end
            default: res = acc_valid ? acc : '0;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rdy_en    <= 1'b0;
         s1_valid  <= 1'b0;
         s1_a      <= '0;
         s1_b      <= '0;
         s1_fun    <= '0;
         cmp_out   <= '0;
         cmp_flag  <= 1'b0;
         acc       <= '0;
         acc_valid <= 1'b0;
      end else begin
         rdy_en <= 1'b1;

         if (s1_load) begin
            s1_valid <= 1'b1;
            s1_a     <= bus.A;
            s1_b     <= bus.B;
            s1_fun   <= bus.ALU_FUN;
         end else if (s2_ready) begin
            s1_valid <= 1'b0;
         end

         // When stage 2 is stalled everything below holds.
         if (s2_ready) begin
            cmp_flag <= s1_valid;
         end
         if (s2_load) begin
            cmp_out   <= res;
            acc       <= acc_nxt;
            acc_valid <= acc_valid_nxt;
         end
      end
   end

`ifdef CMP_HIT_CNT_EN
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         HIT_CNT <= '0;
      end else if (s2_load) begin
         if (acc_clr) begin
            HIT_CNT <= '0;
         end else if (hit && (HIT_CNT != 16'hFFFF)) begin
            HIT_CNT <= HIT_CNT + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cmp_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_cmp_unit_pipe
// Bench for cmp_unit_pipe (WIDTH=16, SIGNED_DEF=0). Inputs are driven 1 ns
// after the rising edge; outputs are observed on the falling edge. Every
// accepted op pushes its expected result to exp_q; the output monitor pops
// and compares on every output transfer and also checks that a stalled
// result stays stable.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cmp_unit_pipe;

   localparam int W = 16;

   logic CLK;
   logic RST;

   cmp_unit_pipe_if #(.WIDTH(W)) bus ();

`ifdef CMP_HIT_CNT_EN
   logic [15:0] hit_cnt;
   cmp_unit_pipe #(.WIDTH(W), .SIGNED_DEF(1'b0)) dut (
      .CLK(CLK), .RST(RST), .bus(bus), .HIT_CNT(hit_cnt)
   );
`else
   cmp_unit_pipe #(.WIDTH(W), .SIGNED_DEF(1'b0)) dut (
      .CLK(CLK), .RST(RST), .bus(bus)
   );
`endif

   int n_checks = 0;
   int n_pass   = 0;
   logic [W-1:0] exp_q[$];

   // ---------------- clock / reset ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- output monitor / scoreboard ----------------
   logic         hold_prev = 1'b0;
   logic [W-1:0] out_prev  = '0;

   always @(negedge CLK) begin
      if (RST) begin
         if (hold_prev) begin
            n_checks++;
            if (bus.CMP_Flag !== 1'b1 || bus.CMP_OUT !== out_prev)
               $display("FAIL stall_hold: flag=%b out=%h, required flag=1 out=%h",
                        bus.CMP_Flag, bus.CMP_OUT, out_prev);
            else
               n_pass++;
         end
         if (bus.CMP_Flag && bus.OUT_Ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_out: out=%h with no op outstanding", bus.CMP_OUT);
            end else begin
               logic [W-1:0] e;
               e = exp_q.pop_front();
               if (bus.CMP_OUT !== e)
                  $display("FAIL result: got %h, required %h", bus.CMP_OUT, e);
               else
                  n_pass++;
            end
         end
      end
      hold_prev = RST && bus.CMP_Flag && !bus.OUT_Ready;
      out_prev  = bus.CMP_OUT;
   end

   // ---------------- driver tasks ----------------
   // Called 1 ns after a rising edge; returns 1 ns after the accepting edge.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] f, input logic [W-1:0] exp);
      bit done;
      done = 1'b0;
      bus.A = a;
      bus.B = b;
      bus.ALU_FUN = f;
      bus.CMP_Enable = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge CLK);
         if (bus.CMP_Ready) begin
            exp_q.push_back(exp);
            done = 1'b1;
         end
         @(posedge CLK);
         #1;
      end
      bus.CMP_Enable = 1'b0;
      if (!done) begin
         n_checks++;
         $display("FAIL send_timeout: op %b never accepted", f);
      end
   endtask

   task automatic drain();
      int i;
      i = 0;
      while (exp_q.size() != 0 && i < 200) begin
         @(posedge CLK);
         #1;
         i++;
      end
      n_checks++;
      if (exp_q.size() != 0)
         $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      else
         n_pass++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // Independent reference for compare-mode ops: widen to 32 bits first.
   function automatic logic [W-1:0] model_cmp(input logic [W-1:0] a,
                                              input logic [W-1:0] b,
                                              input logic [3:0] f);
      int sa;
      int sb;
      sa = f[2] ? int'({{16{a[W-1]}}, a}) : int'({16'h0, a});
      sb = f[2] ? int'({{16{b[W-1]}}, b}) : int'({16'h0, b});
      case (f[1:0])
         2'b01:   return (sa == sb) ? 16'd1 : 16'd0;
         2'b10:   return (sa > sb)  ? 16'd2 : 16'd0;
         2'b11:   return (sa < sb)  ? 16'd3 : 16'd0;
         default: return 16'd0;
      endcase
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      RST = 1'b0;
      bus.A = '0;
      bus.B = '0;
      bus.ALU_FUN = '0;
      bus.CMP_Enable = 1'b0;
      bus.OUT_Ready = 1'b1;
      #23;
      n_checks++;
      if (bus.CMP_OUT !== '0 || bus.CMP_Flag !== 1'b0 || bus.ACC_Valid !== 1'b0)
         $display("FAIL reset_state: out=%h flag=%b accv=%b, required 0/0/0",
                  bus.CMP_OUT, bus.CMP_Flag, bus.ACC_Valid);
      else
         n_pass++;
      @(posedge CLK);
      #1;
      RST = 1'b1;
      @(posedge CLK);
      #1;
      n_checks++;
      if (bus.CMP_Ready !== 1'b1)
         $display("FAIL ready_after_reset: ready=%b, required 1", bus.CMP_Ready);
      else
         n_pass++;
   endtask

   task automatic test_reset_midstream();
      bus.OUT_Ready = 1'b0;
      send(16'd7, 16'd0, 4'b1001, 16'd7);
      @(posedge CLK);
      #1;
      n_checks++;
      if (bus.CMP_Flag !== 1'b1 || bus.ACC_Valid !== 1'b1 || bus.CMP_OUT !== 16'd7)
         $display("FAIL pre_reset_hold: flag=%b accv=%b out=%h, required 1/1/0007",
                  bus.CMP_Flag, bus.ACC_Valid, bus.CMP_OUT);
      else
         n_pass++;
      #2;
      RST = 1'b0;
      #1;
      n_checks++;
      if (bus.CMP_OUT !== '0 || bus.CMP_Flag !== 1'b0 || bus.ACC_Valid !== 1'b0)
         $display("FAIL async_reset: out=%h flag=%b accv=%b, required 0/0/0",
                  bus.CMP_OUT, bus.CMP_Flag, bus.ACC_Valid);
      else
         n_pass++;
      exp_q.delete();
      @(posedge CLK);
      #1;
      RST = 1'b1;
      bus.OUT_Ready = 1'b1;
      @(posedge CLK);
      #1;
      n_checks++;
      if (bus.CMP_Ready !== 1'b1)
         $display("FAIL ready_after_midreset: ready=%b, required 1", bus.CMP_Ready);
      else
         n_pass++;
      // Latency: accepted at the next edge, flag visible after the one after.
      bus.A = 16'd5;
      bus.B = 16'd5;
      bus.ALU_FUN = 4'b0001;
      bus.CMP_Enable = 1'b1;
      exp_q.push_back(16'd1);
      @(posedge CLK);
      #1;
      bus.CMP_Enable = 1'b0;
      n_checks++;
      if (bus.CMP_Flag !== 1'b0)
         $display("FAIL latency_early: flag=%b one cycle after accept, required 0", bus.CMP_Flag);
      else
         n_pass++;
      @(posedge CLK);
      #1;
      n_checks++;
      if (bus.CMP_Flag !== 1'b1 || bus.CMP_OUT !== 16'd1)
         $display("FAIL latency: flag=%b out=%h two cycles after accept, required 1/0001",
                  bus.CMP_Flag, bus.CMP_OUT);
      else
         n_pass++;
      // Accumulator was cleared by reset, so a read returns 0.
      send(16'd0, 16'd0, 4'b1011, 16'd0);
      drain();
   endtask

   task automatic test_compare();
      time t0;
      bus.OUT_Ready = 1'b1;
      t0 = $time;
      send(16'hFFFF, 16'd1, 4'b0010, 16'd2);
      send(16'hFFFF, 16'd1, 4'b0110, 16'd0);
      send(16'hFFFF, 16'd1, 4'b0111, 16'd3);
      send(16'h1234, 16'h1234, 4'b0001, 16'd1);
      n_checks++;
      if (($time - t0) != 40)
         $display("FAIL throughput: 4 ops took %0t, required 40", $time - t0);
      else
         n_pass++;
      drain();
   endtask

   task automatic test_backpressure();
      bit saw_full;
      bit sent;
      saw_full = 1'b0;
      sent = 1'b0;
      bus.OUT_Ready = 1'b1;
      fork
         begin
            send(16'd3, 16'd3, 4'b0001, 16'd1);
            send(16'd5, 16'd2, 4'b0010, 16'd2);
            send(16'd1, 16'd4, 4'b0011, 16'd3);
            send(16'd9, 16'd9, 4'b0000, 16'd0);
            sent = 1'b1;
         end
         begin
            int i;
            i = 0;
            while (!bus.CMP_Flag && i < 50) begin
               @(negedge CLK);
               i++;
            end
            @(posedge CLK);
            #1;
            bus.OUT_Ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(negedge CLK);
               if (!bus.CMP_Ready) saw_full = 1'b1;
               @(posedge CLK);
               #1;
            end
            bus.OUT_Ready = 1'b1;
         end
      join
      drain();
      n_checks++;
      if (!saw_full || !sent)
         $display("FAIL bp_ready_drop: saw_full=%b sent=%b, required 1/1", saw_full, sent);
      else
         n_pass++;
   endtask

   task automatic test_acc_minmax();
      bus.OUT_Ready = 1'b1;
      send(16'd0, 16'd0,    4'b1000, 16'd0);
      send(16'd5, 16'hAAAA, 4'b1001, 16'd5);
      send(16'd9, 16'd0,    4'b1001, 16'd9);
      send(16'd3, 16'd0,    4'b1001, 16'd9);
      send(16'd0, 16'd0,    4'b1011, 16'd9);
      send(16'd2, 16'd0,    4'b1010, 16'd2);
      send(16'h8000, 16'd0, 4'b1110, 16'h8000);
      drain();
      n_checks++;
      if (bus.ACC_Valid !== 1'b1)
         $display("FAIL acc_valid_set: accv=%b, required 1", bus.ACC_Valid);
      else
         n_pass++;
   endtask

   task automatic test_acc_empty();
      bit seen;
      bus.OUT_Ready = 1'b1;
      send(16'd0, 16'd0, 4'b1000, 16'd0);
      send(16'd0, 16'd0, 4'b1011, 16'd0);
      drain();
      idle(1);
      n_checks++;
      if (bus.ACC_Valid !== 1'b0)
         $display("FAIL acc_valid_clear: accv=%b, required 0", bus.ACC_Valid);
      else
         n_pass++;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         if (bus.CMP_Flag) seen = 1'b1;
      end
      @(posedge CLK);
      #1;
      n_checks++;
      if (seen)
         $display("FAIL idle_flag: flag=1 with no input, required 0");
      else
         n_pass++;
   endtask

   task automatic test_random_stream();
      bit done;
      done = 1'b0;
      fork
         begin
            for (int n = 0; n < 24; n++) begin
               logic [W-1:0] a;
               logic [W-1:0] b;
               logic [3:0]   f;
               a = ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 3)) : W'($urandom);
               b = ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 3)) : W'($urandom);
               f = {1'b0, 3'($urandom_range(0, 7))};
               send(a, b, f, model_cmp(a, b, f));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               bus.OUT_Ready = ($urandom_range(0, 2) != 0);
               @(posedge CLK);
               #1;
            end
            bus.OUT_Ready = 1'b1;
         end
      join
      drain();
   endtask

`ifdef CMP_HIT_CNT_EN
   task automatic test_hit_cnt();
      bus.OUT_Ready = 1'b1;
      send(16'd0, 16'd0,    4'b1000, 16'd0);
      send(16'd1, 16'd1,    4'b0001, 16'd1);
      send(16'd2, 16'd1,    4'b0010, 16'd2);
      send(16'd5, 16'd1,    4'b0011, 16'd0);
      send(16'd1, 16'd2,    4'b0001, 16'd0);
      send(16'd1, 16'd5,    4'b0011, 16'd3);
      send(16'd1, 16'hFFFF, 4'b0110, 16'd2);
      drain();
      n_checks++;
      if (hit_cnt !== 16'd4)
         $display("FAIL hit_cnt: got %h, required 0004", hit_cnt);
      else
         n_pass++;
      send(16'd0, 16'd0, 4'b1000, 16'd0);
      drain();
      n_checks++;
      if (hit_cnt !== 16'd0)
         $display("FAIL hit_cnt_clear: got %h, required 0000", hit_cnt);
      else
         n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_compare();
      test_backpressure();
      test_acc_minmax();
      test_acc_empty();
      test_random_stream();
      test_reset_midstream();
`ifdef CMP_HIT_CNT_EN
      test_hit_cnt();
`endif
      idle(2);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
